// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a preload write port, next-PC selection and a registered IF/ID stage.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset (memory is not cleared)
//   stall           hold PC and the IF/ID register
//   flush           squash the IF/ID register (PC still follows stall/sequential)
//   redirect_valid  load redirect_pc into the PC and squash the wrong-path fetch
//   redirect_pc     branch/jump target, loaded without alignment check
//   imem_we         instruction memory write enable (honoured during rst)
//   imem_waddr      instruction memory write word index
//   imem_wdata      instruction memory write data
//   pc_out          current fetch address
//   if_id_pc        address of the latched instruction
//   if_id_pc_plus   if_id_pc + PC_STEP
//   if_id_inst      latched instruction (zero when not valid)
//   if_id_valid     latched instruction is valid
//   fetch_fault     sticky misaligned / out-of-range fetch flag, cleared by rst
module inst_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect_valid,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic [ADDR_WIDTH-1:0]    pc_out,
  output logic [ADDR_WIDTH-1:0]    if_id_pc,
  output logic [ADDR_WIDTH-1:0]    if_id_pc_plus,
  output logic [DATA_WIDTH-1:0]    if_id_inst,
  output logic                     if_id_valid,
  output logic                     fetch_fault
);

  localparam int unsigned           IdxW      = $clog2(DEPTH);
  localparam int unsigned           StepShift = $clog2(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] StepInc   = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(PC_STEP - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [ADDR_WIDTH-1:0] if_plus_q, if_plus_d;
  logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  if_valid_q, if_valid_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] idx_hi;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fetch_bad;
  logic [DATA_WIDTH-1:0] rd_data;

  // Wraps modulo 2^ADDR_WIDTH by construction.
  assign pc_inc   = pc_q + StepInc;
  assign word_idx = pc_q >> StepShift;
  // DEPTH is a power of two, so any set bit above the index field means idx >= DEPTH.
  assign idx_hi       = word_idx >> IdxW;
  assign misaligned   = |(pc_q & AlignMask);
  assign out_of_range = |idx_hi;
  assign fetch_bad    = misaligned | out_of_range;

  // Combinational read; the synchronous write lands after the edge, giving
  // read-before-write on a same-edge collision.
  assign rd_data = mem[word_idx[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_plus_d  = if_plus_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_inst_d  = '0;
      if_valid_d = 1'b0;
    end else begin
      if (!stall) begin
        pc_d      = pc_inc;
        if_pc_d   = pc_q;
        if_plus_d = pc_inc;
        if (fetch_bad) begin
          if_inst_d  = '0;
          if_valid_d = 1'b0;
          fault_d    = 1'b1;
        end else begin
          if_inst_d  = rd_data;
          if_valid_d = 1'b1;
        end
      end
      // Flush only kills the IF/ID contents; PC movement is unaffected.
      if (flush) begin
        if_inst_d  = '0;
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_plus_q  <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_plus_q  <= if_plus_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc_out        = pc_q;
  assign if_id_pc      = if_pc_q;
  assign if_id_pc_plus = if_plus_q;
  assign if_id_inst    = if_inst_q;
  assign if_id_valid   = if_valid_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: default parameters (32-bit addresses, 256 words).
  logic        a_stall, a_flush, a_rv, a_we;
  logic [31:0] a_rpc, a_wdata;
  logic [7:0]  a_waddr;
  logic [31:0] a_pc_out, a_if_pc, a_if_plus, a_inst;
  logic        a_valid, a_fault;

  // Instance B: 8-bit addresses, 64 words, for PC wrap and collision.
  logic        b_stall, b_flush, b_rv, b_we;
  logic [7:0]  b_rpc;
  logic [5:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [7:0]  b_pc_out, b_if_pc, b_if_plus;
  logic [31:0] b_inst;
  logic        b_valid, b_fault;

  inst_fetch_unit u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .stall          (a_stall),
    .flush          (a_flush),
    .redirect_valid (a_rv),
    .redirect_pc    (a_rpc),
    .imem_we        (a_we),
    .imem_waddr     (a_waddr),
    .imem_wdata     (a_wdata),
    .pc_out         (a_pc_out),
    .if_id_pc       (a_if_pc),
    .if_id_pc_plus  (a_if_plus),
    .if_id_inst     (a_inst),
    .if_id_valid    (a_valid),
    .fetch_fault    (a_fault)
  );

  inst_fetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (64),
    .RESET_PC   (8'h00),
    .PC_STEP    (4)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .stall          (b_stall),
    .flush          (b_flush),
    .redirect_valid (b_rv),
    .redirect_pc    (b_rpc),
    .imem_we        (b_we),
    .imem_waddr     (b_waddr),
    .imem_wdata     (b_wdata),
    .pc_out         (b_pc_out),
    .if_id_pc       (b_if_pc),
    .if_id_pc_plus  (b_if_plus),
    .if_id_inst     (b_inst),
    .if_id_valid    (b_valid),
    .fetch_fault    (b_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state as plain integers.
  typedef struct {
    longint pc;
    longint ipc;
    longint iplus;
    longint inst;
    bit     valid;
    bit     fault;
  } st_t;

  st_t    ma, mb;
  longint mem_m [2][256];

  function automatic st_t model_next(st_t s, int which, int aw, int depth, bit r, bit rv,
                                     longint rpc, bit st, bit fl);
    st_t    n;
    longint mask;
    longint nxt;
    n    = s;
    mask = (longint'(1) << aw) - 1;
    if (r) begin
      n = '{pc: 0, ipc: 0, iplus: 0, inst: 0, valid: 0, fault: 0};
      return n;
    end
    if (rv) begin
      n.pc    = rpc & mask;
      n.valid = 0;
      n.inst  = 0;
      return n;
    end
    if (!st) begin
      nxt     = (s.pc + 4) & mask;
      n.ipc   = s.pc;
      n.iplus = nxt;
      n.pc    = nxt;
      if ((s.pc % 4) != 0 || (s.pc / 4) >= depth) begin
        n.valid = 0;
        n.inst  = 0;
        n.fault = 1;
      end else begin
        n.valid = 1;
        n.inst  = mem_m[which][s.pc / 4];
      end
    end
    if (fl) begin
      n.valid = 0;
      n.inst  = 0;
    end
    return n;
  endfunction

  task automatic set_idle();
    a_stall = 0; a_flush = 0; a_rv = 0; a_rpc = '0; a_we = 0; a_waddr = '0; a_wdata = '0;
    b_stall = 0; b_flush = 0; b_rv = 0; b_rpc = '0; b_we = 0; b_waddr = '0; b_wdata = '0;
  endtask

  // One clock edge: advance models with current inputs, then compare both DUTs.
  task automatic step();
    ma = model_next(ma, 0, 32, 256, rst, a_rv, a_rpc, a_stall, a_flush);
    mb = model_next(mb, 1, 8, 64, rst, b_rv, b_rpc, b_stall, b_flush);
    if (a_we) mem_m[0][a_waddr] = a_wdata;
    if (b_we) mem_m[1][b_waddr] = b_wdata;
    @(posedge clk);
    #1;
    check("a_pc", a_pc_out, ma.pc);
    check("a_valid", a_valid, ma.valid);
    check("a_inst", a_inst, ma.inst);
    check("a_fault", a_fault, ma.fault);
    if (ma.valid) begin
      check("a_if_pc", a_if_pc, ma.ipc);
      check("a_if_plus", a_if_plus, ma.iplus);
    end
    check("b_pc", b_pc_out, mb.pc);
    check("b_valid", b_valid, mb.valid);
    check("b_inst", b_inst, mb.inst);
    check("b_fault", b_fault, mb.fault);
    if (mb.valid) begin
      check("b_if_pc", b_if_pc, mb.ipc);
      check("b_if_plus", b_if_plus, mb.iplus);
    end
  endtask

  initial begin
    ma = '{pc: 0, ipc: 0, iplus: 0, inst: 0, valid: 0, fault: 0};
    mb = ma;
    set_idle();
    rst = 1;

    // Preload both memories while held in reset.
    for (int i = 0; i < 256; i++) begin
      a_we    = 1;
      a_waddr = i[7:0];
      case (i)
        0:       a_wdata = 32'h11111111;
        1:       a_wdata = 32'h22222222;
        2:       a_wdata = 32'h33333333;
        3:       a_wdata = 32'h44444444;
        16:      a_wdata = 32'hDEADBEEF;
        default: a_wdata = $urandom;
      endcase
      b_we    = (i < 64);
      b_waddr = i[5:0];
      b_wdata = (i == 0) ? 32'h5A5A5A5A : $urandom;
      step();
    end
    set_idle();
    step();
    check("rst_pc", a_pc_out, 32'h0);
    check("rst_if_pc", a_if_pc, 32'h0);
    check("rst_if_plus", a_if_plus, 32'h0);
    check("rst_inst", a_inst, 32'h0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_fault", a_fault, 1'b0);

    // Sequential fetch from RESET_PC with no bubble.
    rst = 0;
    step();
    check("e1_if_pc", a_if_pc, 32'h0);
    check("e1_inst", a_inst, 32'h11111111);
    check("e1_valid", a_valid, 1'b1);
    check("e1_pc", a_pc_out, 32'h4);
    step();

    // Stall at pc 8.
    a_stall = 1;
    repeat (3) step();
    check("stall_pc", a_pc_out, 32'h8);
    check("stall_if_pc", a_if_pc, 32'h4);
    check("stall_inst", a_inst, 32'h22222222);
    a_stall = 0;
    step();
    check("rel_if_pc", a_if_pc, 32'h8);
    check("rel_if_plus", a_if_plus, 32'hC);
    check("rel_inst", a_inst, 32'h33333333);
    check("rel_pc", a_pc_out, 32'hC);

    // Redirect beats stall.
    a_rv = 1; a_rpc = 32'h40; a_stall = 1;
    step();
    check("redir_pc", a_pc_out, 32'h40);
    check("redir_valid", a_valid, 1'b0);
    check("redir_inst", a_inst, 32'h0);
    a_rv = 0; a_stall = 0;
    step();
    check("tgt_if_pc", a_if_pc, 32'h40);
    check("tgt_inst", a_inst, 32'hDEADBEEF);
    check("tgt_valid", a_valid, 1'b1);

    // Flush, then flush with stall.
    a_rv = 1; a_rpc = 32'h4;
    step();
    a_rv = 0; a_flush = 1;
    step();
    check("flush_valid", a_valid, 1'b0);
    check("flush_inst", a_inst, 32'h0);
    check("flush_pc", a_pc_out, 32'h8);
    a_flush = 0; a_rv = 1; a_rpc = 32'h4;
    step();
    a_rv = 0; a_flush = 1; a_stall = 1;
    step();
    check("flush_stall_pc", a_pc_out, 32'h4);
    check("flush_stall_valid", a_valid, 1'b0);
    set_idle();

    // Out-of-range fetch.
    a_rv = 1; a_rpc = 32'h400;
    step();
    a_rv = 0;
    step();
    check("oor_fault", a_fault, 1'b1);
    check("oor_valid", a_valid, 1'b0);
    check("oor_inst", a_inst, 32'h0);

    // Misaligned fetch, then sticky through good fetches until reset.
    rst = 1;
    step();
    rst = 0; a_rv = 1; a_rpc = 32'h42;
    step();
    a_rv = 0;
    step();
    check("mis_fault", a_fault, 1'b1);
    a_rv = 1; a_rpc = 32'h0;
    step();
    a_rv = 0;
    step();
    step();
    check("sticky_fault", a_fault, 1'b1);
    check("sticky_valid", a_valid, 1'b1);
    check("sticky_inst", a_inst, 32'h22222222);
    rst = 1;
    step();
    rst = 0;
    check("clr_fault", a_fault, 1'b0);

    // PC wrap on the 8-bit instance.
    b_rv = 1; b_rpc = 8'hF8;
    step();
    b_rv = 0;
    step();
    step();
    check("wrap_pc", b_pc_out, 8'h00);
    check("wrap_if_plus", b_if_plus, 8'h00);
    check("wrap_if_pc", b_if_pc, 8'hFC);

    // Same-edge write and fetch of idx 0: old data first, new data on refetch.
    b_we = 1; b_waddr = 6'd0; b_wdata = 32'hAAAA0000;
    step();
    b_we = 0;
    check("coll_old", b_inst, 32'h5A5A5A5A);
    b_rv = 1; b_rpc = 8'h00;
    step();
    b_rv = 0;
    step();
    check("coll_new", b_inst, 32'hAAAA0000);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 59) == 0);
      a_stall = ($urandom_range(0, 3) == 0);
      a_flush = ($urandom_range(0, 5) == 0);
      a_rv    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       a_rpc = $urandom;
        1:       a_rpc = {22'h0, $urandom_range(0, 1023)};
        default: a_rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      a_we    = ($urandom_range(0, 3) == 0);
      a_waddr = 8'($urandom_range(0, 255));
      a_wdata = $urandom;
      b_stall = ($urandom_range(0, 3) == 0);
      b_flush = ($urandom_range(0, 5) == 0);
      b_rv    = ($urandom_range(0, 7) == 0);
      b_rpc   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'($urandom), 2'b00};
      b_we    = ($urandom_range(0, 3) == 0);
      b_waddr = 6'($urandom_range(0, 63));
      b_wdata = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
